pill_bottler: RTL and testbench

Parametrised pill-bottling controller, the next generation of the single-channel pill counter. It fills a batch of bottles, each with a programmable number of pills. It drives the dispensing gate and the conveyor-advance pulse, and keeps a running total of dispensed pills. It sits between the pill-drop sensor and conveyor interface on one side and the operator start/stop controls on the other.

---
 rtl/pill_bottler_if.sv | 31 +++
 rtl/pill_bottler.sv | 173 +++++++++++++++++
 tb/tb_pill_bottler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pill_bottler_if.sv
// Bundle of operator controls, sensor/conveyor signals and status outputs
// for the pill bottling controller. The controller takes the slave modport;
// whatever drives the controls takes the master modport.
interface pill_bottler_if #(
    parameter int PILL_W   = 6,
    parameter int COUNT_W  = 10,
    parameter int BOTTLE_W = 8
);
    logic [PILL_W-1:0]   pillc;
    logic [BOTTLE_W-1:0] nbottles;
    logic                start;
    logic                stop;
    logic                pill_in;
    logic                bottle_rdy;
    logic                gate;
    logic                advance;
    logic [COUNT_W-1:0]  countp;
    logic [BOTTLE_W-1:0] bottles;
    logic                busy;
    logic                done;

    modport master (
        output pillc, nbottles, start, stop, pill_in, bottle_rdy,
        input  gate, advance, countp, bottles, busy, done
    );

    modport slave (
        input  pillc, nbottles, start, stop, pill_in, bottle_rdy,
        output gate, advance, countp, bottles, busy, done
    );
endinterface

// File: rtl/pill_bottler.sv
// Pill bottling controller: fills a batch of bottles with a programmable
// number of pills each, opens the gate while filling, pulses the conveyor
// advance after every bottle and keeps a running total of dispensed pills.
// All outputs are registered copies of the state being entered.
module pill_bottler #(
    parameter int PILL_W   = 6,
    parameter int COUNT_W  = 10,
    parameter int BOTTLE_W = 8,
    parameter int SAT      = 0
) (
    input  logic           clk,
    input  logic           rst,
    pill_bottler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_BOTTLE = 3'd1,
        FILL        = 3'd2,
        ADVANCE     = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                armed_q, armed_d;       // edge detector valid only after the first post-reset edge
    logic                start_q, start_d;       // previous start level
    logic                go_q, go_d;             // qualified start edge, acted on one cycle later
    logic [PILL_W-1:0]   target_q, target_d;
    logic [BOTTLE_W-1:0] nbot_q, nbot_d;
    logic [PILL_W-1:0]   fill_q, fill_d;
    logic                stop_lat_q, stop_lat_d;
    logic [COUNT_W-1:0]  countp_q, countp_d;
    logic [BOTTLE_W-1:0] bottles_q, bottles_d;
    logic                gate_q, gate_d;
    logic                advance_q, advance_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                start_rise;
    logic [PILL_W-1:0]   fill_inc;
    logic [BOTTLE_W-1:0] bottles_inc;
    logic [COUNT_W-1:0]  countp_inc;

    // Start edge detection; a start already high when reset releases is not an edge.
    always_comb begin
        start_rise  = armed_q & bus.start & ~start_q;
        fill_inc    = fill_q + 1'b1;
        bottles_inc = bottles_q + 1'b1;
        if ((SAT != 0) && (countp_q == {COUNT_W{1'b1}})) begin
            countp_inc = countp_q;
        end else begin
            countp_inc = countp_q + 1'b1;
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b1;
        start_d    = bus.start;
        go_d       = 1'b0;
        target_d   = target_q;
        nbot_d     = nbot_q;
        fill_d     = fill_q;
        stop_lat_d = stop_lat_q;
        countp_d   = countp_q;
        bottles_d  = bottles_q;

        // Settings are captured on the qualifying edge; the batch starts on the following edge.
        if ((state_q == IDLE) && start_rise && (bus.pillc != '0)) begin
            go_d     = 1'b1;
            target_d = bus.pillc;
            nbot_d   = bus.nbottles;
        end

        if ((state_q != IDLE) && bus.stop) begin
            stop_lat_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (go_q) begin
                    state_d    = WAIT_BOTTLE;
                    bottles_d  = '0;
                    fill_d     = '0;
                    stop_lat_d = 1'b0;
                end
            end
            WAIT_BOTTLE: begin
                if (stop_lat_q) begin
                    state_d = DONE;
                end else if (bus.bottle_rdy) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // Once the gate is open the bottle is committed; bottle_rdy is not rechecked.
                if (bus.pill_in) begin
                    fill_d   = fill_inc;
                    countp_d = countp_inc;
                    if (fill_inc == target_q) begin
                        state_d = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                bottles_d = bottles_inc;
                fill_d    = '0;
                if ((nbot_q != '0) && (bottles_inc == nbot_q)) begin
                    state_d = DONE;
                end else if (stop_lat_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_BOTTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gate_d    = (state_d == FILL);
        advance_d = (state_d == ADVANCE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            start_q    <= 1'b0;
            go_q       <= 1'b0;
            target_q   <= '0;
            nbot_q     <= '0;
            fill_q     <= '0;
            stop_lat_q <= 1'b0;
            countp_q   <= '0;
            bottles_q  <= '0;
            gate_q     <= 1'b0;
            advance_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            start_q    <= start_d;
            go_q       <= go_d;
            target_q   <= target_d;
            nbot_q     <= nbot_d;
            fill_q     <= fill_d;
            stop_lat_q <= stop_lat_d;
            countp_q   <= countp_d;
            bottles_q  <= bottles_d;
            gate_q     <= gate_d;
            advance_q  <= advance_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.gate    = gate_q;
    assign bus.advance = advance_q;
    assign bus.countp  = countp_q;
    assign bus.bottles = bottles_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_pill_bottler.sv
// Bench for pill_bottler: three instances share one stimulus (default
// 10-bit wrapping counter, 4-bit wrapping counter, 4-bit saturating counter).
// A negedge monitor tracks pills accepted through the open gate and checks
// totals and per-bottle fills; directed steps and random batches follow.
module tb_pill_bottler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pillc = '0;
    logic [7:0] nbottles = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pill_in = 1'b0;
    logic       bottle_rdy = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    // reference-model state owned by the monitor
    int exp_total    = 0;
    int bottle_pills = 0;
    int adv_total    = 0;
    int done_total   = 0;
    logic prev_adv   = 1'b0;
    logic prev_done  = 1'b0;

    // owned by the stimulus
    int cur_pillc = 0;
    bit rnd_mode  = 1'b0;

    always #5 clk = ~clk;

    pill_bottler_if #(.PILL_W(6), .COUNT_W(10), .BOTTLE_W(8)) if0 ();
    pill_bottler_if #(.PILL_W(6), .COUNT_W(4),  .BOTTLE_W(8)) if1 ();
    pill_bottler_if #(.PILL_W(6), .COUNT_W(4),  .BOTTLE_W(8)) if2 ();

    assign if0.pillc = pillc;  assign if0.nbottles = nbottles; assign if0.start = start;
    assign if0.stop = stop;    assign if0.pill_in = pill_in;   assign if0.bottle_rdy = bottle_rdy;
    assign if1.pillc = pillc;  assign if1.nbottles = nbottles; assign if1.start = start;
    assign if1.stop = stop;    assign if1.pill_in = pill_in;   assign if1.bottle_rdy = bottle_rdy;
    assign if2.pillc = pillc;  assign if2.nbottles = nbottles; assign if2.start = start;
    assign if2.stop = stop;    assign if2.pill_in = pill_in;   assign if2.bottle_rdy = bottle_rdy;

    pill_bottler #(.PILL_W(6), .COUNT_W(10), .BOTTLE_W(8), .SAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    pill_bottler #(.PILL_W(6), .COUNT_W(4),  .BOTTLE_W(8), .SAT(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    pill_bottler #(.PILL_W(6), .COUNT_W(4),  .BOTTLE_W(8), .SAT(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Monitor: the gate is open exactly while filling, so every cycle with
    // gate and pill_in high is one dispensed pill, counted one edge later.
    always @(negedge clk) begin
        if (rst) begin
            exp_total    = 0;
            bottle_pills = 0;
            prev_adv     = 1'b0;
            prev_done    = 1'b0;
        end else begin
            check("countp_w10", 32'(if0.countp), 32'(exp_total % 1024));
            check("countp_w4_wrap", 32'(if1.countp), 32'(exp_total % 16));
            check("countp_w4_sat", 32'(if2.countp), 32'((exp_total > 15) ? 15 : exp_total));
            check("gate_when_idle", 32'(if0.gate & ~if0.busy), 32'(0));
            if (if0.advance) begin
                adv_total++;
                check("pills_per_bottle", 32'(bottle_pills), 32'(cur_pillc));
                check("gate_in_advance", 32'(if0.gate), 32'(0));
                check("advance_one_cycle", 32'(prev_adv), 32'(0));
                bottle_pills = 0;
            end
            if (if0.done) begin
                done_total++;
                check("busy_in_done", 32'(if0.busy), 32'(1));
                check("done_one_cycle", 32'(prev_done), 32'(0));
            end
            if (if0.gate && pill_in) begin
                bottle_pills++;
                exp_total++;
            end
            prev_adv  = if0.advance;
            prev_done = if0.done;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                pill_in    = 1'($urandom_range(0, 1));
                bottle_rdy = ($urandom_range(0, 9) < 7);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // One batch: start edge, run until the done pulse, then check the outcome.
    task automatic run_batch(input int pc, input int nb, input int stop_cyc,
                             input int stop_b, input int stop_p);
        int base_total, base_adv, base_done, cyc, nadv;
        pillc    = 6'(pc);
        nbottles = 8'(nb);
        start    = 1'b0;
        stop     = 1'b0;
        step(1);
        base_total = exp_total;
        base_adv   = adv_total;
        base_done  = done_total;
        cur_pillc  = pc;
        start = 1'b1;
        step(1);
        check("busy_edge_n", 32'(if0.busy), 32'(0));
        step(1);
        check("busy_edge_n1", 32'(if0.busy), 32'(1));
        cyc = 0;
        while (done_total == base_done && cyc < 3000) begin
            if (stop_cyc >= 0 && cyc >= stop_cyc) stop = 1'b1;
            if (stop_b >= 0 && (adv_total - base_adv) == stop_b && bottle_pills >= stop_p) stop = 1'b1;
            step(1);
            cyc++;
        end
        check("batch_timeout", 32'(cyc < 3000), 32'(1));
        check("busy_after_done", 32'(if0.busy), 32'(0));
        stop  = 1'b0;
        start = 1'b0;
        nadv = adv_total - base_adv;
        $display("batch pillc=%0d nbottles=%0d stop_cyc=%0d -> bottles=%0d countp=%0d cycles=%0d",
                 pc, nb, stop_cyc, if0.bottles, if0.countp, cyc);
        check("done_pulses", 32'(done_total - base_done), 32'(1));
        check("bottles_out", 32'(if0.bottles), 32'(nadv));
        if (stop_cyc < 0 && stop_b < 0) check("bottles_vs_nbottles", 32'(nadv), 32'(nb));
        check("countp_batch", 32'(if0.countp), 32'((base_total + pc * nadv) % 1024));
    endtask

    initial begin
        int cyc, base_adv, base_done, pc, nb, sc;

        // reset state, with start held high through release
        start = 1'b1;
        rst   = 1'b1;
        step(2);
        check("rst_gate", 32'(if0.gate), 32'(0));
        check("rst_advance", 32'(if0.advance), 32'(0));
        check("rst_busy", 32'(if0.busy), 32'(0));
        check("rst_done", 32'(if0.done), 32'(0));
        check("rst_countp", 32'(if0.countp), 32'(0));
        check("rst_bottles", 32'(if0.bottles), 32'(0));
        rst = 1'b0;
        step(8);
        check("start_through_reset", 32'(if0.busy), 32'(0));
        $display("reset and start-held-through-release checked");

        // start rise with pillc == 0 is ignored; a later pillc change is not an edge
        start = 1'b0;
        pillc = '0;
        step(1);
        start = 1'b1;
        step(4);
        check("start_pillc0", 32'(if0.busy), 32'(0));
        pillc = 6'd3;
        step(3);
        check("start_level_no_edge", 32'(if0.busy), 32'(0));
        start = 1'b0;
        $display("start with pillc=0 checked");

        // basic batch
        pill_in    = 1'b1;
        bottle_rdy = 1'b1;
        run_batch(3, 2, -1, -1, 0);
        check("basic_countp", 32'(if0.countp), 32'(6));
        check("basic_bottles", 32'(if0.bottles), 32'(2));
        step(3);
        check("bottles_hold", 32'(if0.bottles), 32'(2));

        // gating: pills outside FILL are ignored
        do_reset();
        pill_in    = 1'b0;
        bottle_rdy = 1'b0;
        pillc      = 6'd4;
        nbottles   = 8'd1;
        cur_pillc  = 4;
        for (int i = 0; i < 6; i++) begin
            pill_in = i[0];
            step(1);
        end
        check("gating_idle_countp", 32'(if0.countp), 32'(0));
        pill_in = 1'b0;
        step(1);
        start = 1'b1;
        step(2);
        check("gating_busy", 32'(if0.busy), 32'(1));
        base_done = done_total;
        for (int i = 0; i < 6; i++) begin
            pill_in = ~i[0];
            step(1);
        end
        check("gating_wait_gate", 32'(if0.gate), 32'(0));
        check("gating_wait_countp", 32'(if0.countp), 32'(0));
        pill_in    = 1'b0;
        bottle_rdy = 1'b1;
        step(1);
        check("gate_latency", 32'(if0.gate), 32'(1));
        bottle_rdy = 1'b0;
        pill_in    = 1'b1;
        cyc = 0;
        while (done_total == base_done && cyc < 50) begin
            step(1);
            cyc++;
        end
        check("gating_timeout", 32'(cyc < 50), 32'(1));
        check("gating_countp", 32'(if0.countp), 32'(4));
        check("gating_bottles", 32'(if0.bottles), 32'(1));
        check("gating_busy_end", 32'(if0.busy), 32'(0));
        start   = 1'b0;
        pill_in = 1'b0;
        $display("gating batch countp=%0d", if0.countp);

        // stop mid-fill in continuous mode: bottle 3 still completes
        do_reset();
        pill_in    = 1'b1;
        bottle_rdy = 1'b1;
        run_batch(5, 0, -1, 2, 2);
        check("stop_bottles", 32'(if0.bottles), 32'(3));
        check("stop_countp", 32'(if0.countp), 32'(15));

        // wrap and saturate on the narrow counters
        do_reset();
        run_batch(6, 3, -1, -1, 0);
        check("wide_countp", 32'(if0.countp), 32'(18));
        check("wrap_countp", 32'(if1.countp), 32'(2));
        check("sat_countp", 32'(if2.countp), 32'(15));

        // asynchronous reset mid-batch, after one pill of bottle 2
        do_reset();
        pillc     = 6'd3;
        nbottles  = 8'd0;
        cur_pillc = 3;
        start     = 1'b0;
        step(1);
        start    = 1'b1;
        base_adv = adv_total;
        cyc = 0;
        while (!((adv_total - base_adv) == 1 && bottle_pills == 1) && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("midrst_timeout", 32'(cyc < 100), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_gate", 32'(if0.gate), 32'(0));
        check("midrst_busy", 32'(if0.busy), 32'(0));
        check("midrst_countp", 32'(if0.countp), 32'(0));
        check("midrst_bottles", 32'(if0.bottles), 32'(0));
        $display("reset mid-batch applied");
        step(1);
        rst   = 1'b0;
        start = 1'b0;
        step(1);
        run_batch(2, 1, -1, -1, 0);
        check("after_rst_countp", 32'(if0.countp), 32'(2));
        check("after_rst_bottles", 32'(if0.bottles), 32'(1));

        // random batches with random sensor and bottle-ready activity
        rnd_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = $urandom_range(1, 8);
            nb = $urandom_range(0, 4);
            if (nb == 0) sc = $urandom_range(5, 60);
            else if ($urandom_range(0, 3) == 0) sc = $urandom_range(5, 40);
            else sc = -1;
            run_batch(pc, nb, sc, -1, 0);
        end
        rnd_mode = 1'b0;
        pill_in  = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
